complex_result_tx: RTL and testbench

//  Producer (transmitter) end of the complex multiplier result interface (res_val/res_ready/res_data).

---
 rtl/complex_result_tx_pkg.sv | 26 ++
 rtl/complex_result_tx_fifo.sv | 82 ++++++++
 rtl/complex_result_tx.sv | 122 ++++++++++++
 tb/tb_complex_result_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/complex_result_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : complex_result_tx_pkg
// Description : Shared types and constants for the complex multiplier result
//               transmitter: FSM state encoding, default widths and a helper
//               that derives the packed {re, im} result width.
// Revision    : 1.0  - initial release
// ============================================================================
package complex_result_tx_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 16;
    localparam int c_DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    // Packed result width: real part in the MSBs, imaginary part in the LSBs
    function automatic int res_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_result_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : complex_result_tx_fifo
// Description : Synchronous result FIFO. A push is accepted when there is
//               room or when a pop happens on the same edge. The count is one
//               bit wider than the pointers so full and empty are distinct.
// Revision    : 1.0  - initial release
// ============================================================================
module complex_result_tx_fifo
    import complex_result_tx_pkg::*;
#(
    parameter int WIDTH = res_width(c_DEFAULT_DATA_WIDTH),
    parameter int DEPTH = c_DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_sw_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_ADDR_W   = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop on the same edge frees the slot the push needs
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;

    // Storage array: data only, no reset needed since pointers gate reads
    always_ff @(posedge clk) begin
        if (w_do_push && !i_sw_rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; soft reset has priority over push/pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_sw_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/complex_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : complex_result_tx
// Description : Producer end of the complex multiplier result interface.
//               Buffers {re, im} results in a FIFO and presents them one at
//               a time on res_val/res_ready, forcing res_val low for at least
//               one cycle between transfers.
// Revision    : 1.0  - initial release
// ============================================================================
module complex_result_tx
    import complex_result_tx_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = c_DEFAULT_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    core_val,
    input  logic [DATA_WIDTH-1:0]   core_re,
    input  logic [DATA_WIDTH-1:0]   core_im,
    output logic                    buf_full,
    output logic                    ovf,
    output logic                    res_val,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data
);

    localparam int c_RES_W = res_width(DATA_WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_res_val;
    logic               w_res_val_nxt;
    logic [c_RES_W-1:0] r_res_data;
    logic [c_RES_W-1:0] w_res_data_nxt;
    logic               r_ovf;

    logic               w_pop;
    logic [c_RES_W-1:0] w_fifo_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_drop;

    complex_result_tx_fifo #(
        .WIDTH (c_RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_sw_rst    (sw_rst),
        .i_push      (core_val),
        .i_push_data ({core_re, core_im}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // A result is lost only when the FIFO is full and nothing leaves it this edge
    assign w_drop = core_val & w_fifo_full & ~w_pop;

    assign buf_full = w_fifo_full;
    assign ovf      = r_ovf;
    assign res_val  = r_res_val;
    assign res_data = r_res_data;

    // Next-state and registered-output decode for the presentation FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_res_val_nxt  = r_res_val;
        w_res_data_nxt = r_res_data;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_res_val_nxt  = 1'b1;
                    w_res_data_nxt = w_fifo_data;
                    w_state_nxt    = PRESENT;
                end
            end
            PRESENT: begin
                if (res_ready) begin
                    w_res_val_nxt = 1'b0;
                    w_state_nxt   = GAP;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_res_val_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // State, output register and sticky overflow; soft reset wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_res_val  <= 1'b0;
            r_res_data <= '0;
            r_ovf      <= 1'b0;
        end else if (sw_rst) begin
            r_state    <= IDLE;
            r_res_val  <= 1'b0;
            r_res_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_res_val  <= w_res_val_nxt;
            r_res_data <= w_res_data_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_complex_result_tx
// Description : Directed self-checking bench for complex_result_tx.
// Revision    : 1.0  - initial release
// ============================================================================
module tb_complex_result_tx;

    logic        clk;
    logic        rstn;
    logic        sw_rst;
    logic        core_val;
    logic [15:0] core_re;
    logic [15:0] core_im;
    logic        buf_full;
    logic        ovf;
    logic        res_val;
    logic        res_ready;
    logic [31:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    complex_result_tx #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .core_val  (core_val),
        .core_re   (core_re),
        .core_im   (core_im),
        .buf_full  (buf_full),
        .ovf       (ovf),
        .res_val   (res_val),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] re, input logic [15:0] im);
        core_val = 1'b1;
        core_re  = re;
        core_im  = im;
        tick();
        core_val = 1'b0;
    endtask

    // Wait (bounded) for res_val, check the word, hold ready low for delay cycles, then hand-shake
    task automatic xfer(input string tag, input logic [31:0] exp, input int delay);
        for (int i = 0; i < 12; i++) begin
            if (res_val) break;
            tick();
        end
        chk({tag, "_val"}, res_val, 1'b1);
        chk({tag, "_data"}, res_data, exp);
        repeat (delay) tick();
        chk({tag, "_held"}, {res_val, res_data}, {1'b1, exp});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_fall"}, res_val, 1'b0);
    endtask

    // Confirm res_val stays low for a number of cycles
    task automatic quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (res_val) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    logic [31:0] exp_q [6];

    initial begin
        rstn      = 1'b0;
        sw_rst    = 1'b0;
        core_val  = 1'b0;
        core_re   = '0;
        core_im   = '0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {res_val, res_data, buf_full, ovf}, 35'h0);
        rstn = 1'b1;
        tick();

        // Single result with ready held high: visible one edge after push
        res_ready = 1'b1;
        push(16'h0003, 16'hFFFE);
        chk("lat_not_yet", res_val, 1'b0);
        tick();
        chk("lat_val", res_val, 1'b1);
        chk("lat_data", res_data, 32'h0003_FFFE);
        tick();
        chk("held_ready_xfer", res_val, 1'b0);
        tick();
        chk("gap_low", res_val, 1'b0);
        res_ready = 1'b0;
        quiet("single_no_dup", 4);

        // Long consumer stall: data must not move
        push(16'h1234, 16'h5678);
        tick();
        chk("stall_val_rise", res_val, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_hold", {res_val, res_data}, {1'b1, 32'h1234_5678});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("stall_xfer_fall", res_val, 1'b0);
        quiet("stall_no_dup", 5);

        // Overflow: 6 back-to-back pushes, 1 in output register + 4 queued, 6th dropped
        for (int k = 0; k < 6; k++) begin
            push(16'h0100 + 16'(k), 16'h0A00 + 16'(k));
            if (k == 4) chk("full_after_5", {buf_full, ovf}, 2'b10);
        end
        chk("ovf_after_6", {buf_full, ovf}, 2'b11);
        xfer("ovf_x0", 32'h0100_0A00, 20);
        xfer("ovf_x1", 32'h0101_0A01, 20);
        xfer("ovf_x2", 32'h0102_0A02, 20);
        xfer("ovf_x3", 32'h0103_0A03, 20);
        xfer("ovf_x4", 32'h0104_0A04, 20);
        quiet("ovf_no_sixth", 8);
        chk("ovf_sticky", {buf_full, ovf}, 2'b01);

        // Soft reset while presenting with two entries queued
        push(16'h00AA, 16'h0001);
        push(16'h00BB, 16'h0002);
        push(16'h00CC, 16'h0003);
        chk("swr_pre_val", res_val, 1'b1);
        chk("swr_pre_count", dut.u_fifo.r_count, 3'd2);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("swr_outputs", {res_val, res_data, buf_full, ovf}, 35'h0);
        chk("swr_count", dut.u_fifo.r_count, 3'd0);
        quiet("swr_no_val", 8);

        // Full FIFO, IDLE pops while a new result arrives on the same edge
        for (int k = 0; k < 6; k++) exp_q[k] = {16'h0200 + 16'(k), 16'h0B00 + 16'(k)};
        for (int k = 0; k < 5; k++) push(exp_q[k][31:16], exp_q[k][15:0]);
        chk("simul_setup_full", {buf_full, ovf, res_data}, {2'b10, exp_q[0]});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        push(exp_q[5][31:16], exp_q[5][15:0]);
        chk("simul_flags", {buf_full, ovf}, 2'b10);
        chk("simul_head", {res_val, res_data}, {1'b1, exp_q[1]});
        for (int k = 1; k < 6; k++) xfer("simul_x", exp_q[k], 0);
        quiet("simul_drained", 8);
        chk("simul_no_ovf", ovf, 1'b0);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 6; k++) push(16'h0300 + 16'(k), 16'h0C00 + 16'(k));
        chk("arst_pre", {res_val, buf_full, ovf}, 3'b111);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_immediate", {res_val, res_data, buf_full, ovf}, 35'h0);
        tick();
        rstn = 1'b1;
        quiet("arst_discarded", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
